// File: rtl/hack_rom_loader.sv
// Serial bootloader for the Hack instruction memory: assembles framed UART bytes
// into 16-bit words, writes them to ROM and holds the CPU in reset while loading.
module hack_rom_loader #(
  parameter int          DEPTH   = 1024,
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter int          TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rom_we,
  output logic [15:0] rom_addr,
  output logic [15:0] rom_data,
  output logic        cpu_reset,
  output logic        loaded,
  output logic        error
);

  localparam int             TW      = $clog2(TIMEOUT + 1);
  localparam logic [16:0]    DEPTH17 = 17'(DEPTH);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR
  } state_t;

  state_t         state, nxt_state;
  logic [15:0]    len, nxt_len;
  logic [15:0]    cnt, nxt_cnt;
  logic [7:0]     hi, nxt_hi;
  logic [7:0]     acc, nxt_acc;
  logic [TW-1:0]  tcnt, nxt_tcnt;
  logic           nxt_rom_we, nxt_cpu_reset, nxt_loaded, nxt_error;
  logic [15:0]    nxt_rom_addr, nxt_rom_data;

  logic [15:0]    frame_len;
  logic [15:0]    cnt_inc;
  logic           in_frame;

  assign frame_len = {len[15:8], rx_data};
  assign cnt_inc   = cnt + 16'd1;
  assign in_frame  = (state == LEN_HI) || (state == LEN_LO) || (state == DATA_HI) ||
                     (state == DATA_LO) || (state == CHECK);

  // NOTE: every sequential register uses non-blocking assignment so all state
  // updates see the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      len       <= '0;
      cnt       <= '0;
      hi        <= '0;
      acc       <= '0;
      tcnt      <= '0;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_data  <= '0;
      cpu_reset <= 1'b0;
      loaded    <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= nxt_state;
      len       <= nxt_len;
      cnt       <= nxt_cnt;
      hi        <= nxt_hi;
      acc       <= nxt_acc;
      tcnt      <= nxt_tcnt;
      rom_we    <= nxt_rom_we;
      rom_addr  <= nxt_rom_addr;
      rom_data  <= nxt_rom_data;
      cpu_reset <= nxt_cpu_reset;
      loaded    <= nxt_loaded;
      error     <= nxt_error;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value unassigned (no latches).
    nxt_state     = state;
    nxt_len       = len;
    nxt_cnt       = cnt;
    nxt_hi        = hi;
    nxt_acc       = acc;
    nxt_tcnt      = tcnt;
    nxt_rom_we    = 1'b0;
    nxt_rom_addr  = rom_addr;
    nxt_rom_data  = rom_data;
    nxt_cpu_reset = cpu_reset;
    nxt_loaded    = loaded;
    nxt_error     = error;

    // Inter-byte watchdog; a byte arrival and an expiry are mutually exclusive.
    if (in_frame && !rx_valid) begin
      if (tcnt == TO_LAST) begin
        nxt_state = ERROR;
        nxt_error = 1'b1;
      end else begin
        nxt_tcnt = tcnt + 1'b1;
      end
    end else if (in_frame) begin
      nxt_tcnt = '0;
    end

    if (rx_valid) begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (rx_data == SYNC) begin
            nxt_state     = LEN_HI;
            nxt_cpu_reset = 1'b1;
            nxt_loaded    = 1'b0;
            nxt_error     = 1'b0;
            nxt_cnt       = '0;
            nxt_acc       = '0;
            nxt_tcnt      = '0;
          end
        end
        LEN_HI: begin
          nxt_len   = {rx_data, 8'h00};
          nxt_state = LEN_LO;
        end
        LEN_LO: begin
          nxt_len = frame_len;
          if (frame_len == 16'd0 || {1'b0, frame_len} > DEPTH17) begin
            nxt_state = ERROR;
            nxt_error = 1'b1;
          end else begin
            nxt_state = DATA_HI;
          end
        end
        DATA_HI: begin
          nxt_hi    = rx_data;
          nxt_acc   = acc ^ rx_data;
          nxt_state = DATA_LO;
        end
        DATA_LO: begin
          nxt_acc      = acc ^ rx_data;
          nxt_rom_we   = 1'b1;
          nxt_rom_addr = cnt;
          nxt_rom_data = {hi, rx_data};
          nxt_cnt      = cnt_inc;
          nxt_state    = (cnt_inc == len) ? CHECK : DATA_HI;
        end
        CHECK: begin
          if (rx_data == acc) begin
            nxt_state     = DONE;
            nxt_loaded    = 1'b1;
            nxt_cpu_reset = 1'b0;
          end else begin
            nxt_state = ERROR;
            nxt_error = 1'b1;
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

endmodule
